// File: rtl/hsv_core_mem_arbiter.sv
// Two-requester round-robin arbiter for the core data-memory port, with a
// registered request stage and an in-order routing FIFO for responses.
module hsv_core_mem_arbiter #(
    parameter int MaxOutstanding = 4,
    parameter int AddrWidth      = 32
) (
    input  logic                      clk_core,
    input  logic                      rst_core_n,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0][AddrWidth-1:0] req_address,
    input  logic [1:0]                req_write,
    input  logic [1:0][31:0]          req_write_data,
    input  logic [1:0][3:0]           req_write_strobe,
    output logic                      dmem_valid,
    input  logic                      dmem_ready,
    output logic [AddrWidth-1:0]      dmem_address,
    output logic                      dmem_write,
    output logic [31:0]               dmem_write_data,
    output logic [3:0]                dmem_write_strobe,
    input  logic                      dmem_rsp_valid,
    input  logic [31:0]               dmem_rsp_data,
    input  logic                      dmem_rsp_error,
    output logic [1:0]                rsp_valid,
    output logic [31:0]               rsp_data,
    output logic                      rsp_error,
    output logic                      protocol_error
);

    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = PtrW + 1;

    logic [CntW-1:0] count;
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            fifo_id [MaxOutstanding];
    logic            rr_last;

    logic slot_free;
    logic can_grant;
    logic grant;
    logic grant_id;
    logic pop;
    logic head_id;

    // count is the start-of-cycle value, so a response arriving this cycle
    // cannot open a slot in a full FIFO until the next cycle.
    assign slot_free = ~dmem_valid | dmem_ready;
    assign can_grant = slot_free & (count < CntW'(MaxOutstanding));

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        req_ready = 2'b00;
        if (can_grant) begin
            if (req_valid == 2'b11) begin
                req_ready[~rr_last] = 1'b1;
            end else if (req_valid[0]) begin
                req_ready[0] = 1'b1;
            end else if (req_valid[1]) begin
                req_ready[1] = 1'b1;
            end
        end
    end

    assign grant    = |(req_valid & req_ready);
    assign grant_id = req_ready[1];
    assign pop      = dmem_rsp_valid & (count != '0);
    assign head_id  = fifo_id[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            dmem_valid        <= 1'b0;
            dmem_address      <= '0;
            dmem_write        <= 1'b0;
            dmem_write_data   <= '0;
            dmem_write_strobe <= '0;
            rr_last           <= 1'b1;
        end else if (grant) begin
            dmem_valid        <= 1'b1;
            dmem_address      <= req_address[grant_id];
            dmem_write        <= req_write[grant_id];
            dmem_write_data   <= req_write_data[grant_id];
            dmem_write_strobe <= req_write_strobe[grant_id];
            rr_last           <= grant_id;
        end else if (dmem_ready) begin
            dmem_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (grant) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            unique case ({grant, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the id storage carries no reset; only the pointers and count
    // decide which entries are live.
    always_ff @(posedge clk_core) begin
        if (grant) begin
            fifo_id[wr_ptr] <= grant_id;
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            rsp_valid      <= 2'b00;
            rsp_data       <= '0;
            rsp_error      <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            rsp_valid <= pop ? (head_id ? 2'b10 : 2'b01) : 2'b00;
            rsp_data  <= dmem_rsp_data;
            rsp_error <= dmem_rsp_error;
            if (dmem_rsp_valid && count == '0) begin
                protocol_error <= 1'b1;
            end
        end
    end

endmodule
